// File: rtl/status_reg.sv
// Processor status register (P): flag updates from the ALU, SET_CTRL and DB_IN, NMI edge detect, IRQ take request.
// Latency: FLAG, IRQ_PEND and NMI_PEND are all registered and update one cycle after their inputs; PUSH_DATA is combinational from P.
// Backpressure: none; every input is sampled on each rising edge. Define STATUS_REG_DECIMAL_EN to make the D flag writable.
module status_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_flag,
  input  logic [7:0] flag_we,
  input  logic [2:0] set_ctrl,
  input  logic [7:0] db_in,
  input  logic       load_db,
  input  logic       push_brk,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       instr_end,
  input  logic       int_ack,
  input  logic       nmi_ack,
  output logic [7:0] flag,
  output logic [7:0] push_data,
  output logic       irq_pend,
  output logic       nmi_pend
);

  localparam logic [2:0] SC_NONE = 3'd0;
  localparam logic [2:0] SC_CLC  = 3'd1;
  localparam logic [2:0] SC_SEC  = 3'd2;
  localparam logic [2:0] SC_CLI  = 3'd3;
  localparam logic [2:0] SC_SEI  = 3'd4;
  localparam logic [2:0] SC_CLD  = 3'd5;
  localparam logic [2:0] SC_SED  = 3'd6;
  localparam logic [2:0] SC_CLV  = 3'd7;

  // Stored flags; bits 5 and 4 of P are constants and have no storage.
  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic c_d, z_d, i_d, v_d, n_d;
  logic nmi_smp_q;
  logic nmi_pend_q;
  logic irq_pend_q;
  logic nmi_edge;

`ifdef STATUS_REG_DECIMAL_EN
  logic d_d;
  logic unused_bits;
  assign unused_bits = ^{alu_flag[5:4], flag_we[5:4], db_in[5:4]};
`else
  // D is hardwired to 0, so its write sources are deliberately left unconnected.
  logic unused_bits;
  assign unused_bits = ^{alu_flag[5:3], flag_we[5:3], db_in[5:3]};
`endif

  // Next-P selection: DB restore beats SET_CTRL beats the ALU write mask; INT_ACK forces I last.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    v_d = v_q;
    n_d = n_q;
`ifdef STATUS_REG_DECIMAL_EN
    d_d = d_q;
`endif
    if (load_db) begin
      c_d = db_in[0];
      z_d = db_in[1];
      i_d = db_in[2];
      v_d = db_in[6];
      n_d = db_in[7];
`ifdef STATUS_REG_DECIMAL_EN
      d_d = db_in[3];
`endif
    end else if (set_ctrl != SC_NONE) begin
      case (set_ctrl)
        SC_CLC:  c_d = 1'b0;
        SC_SEC:  c_d = 1'b1;
        SC_CLI:  i_d = 1'b0;
        SC_SEI:  i_d = 1'b1;
`ifdef STATUS_REG_DECIMAL_EN
        SC_CLD:  d_d = 1'b0;
        SC_SED:  d_d = 1'b1;
`else
        SC_CLD:  ;
        SC_SED:  ;
`endif
        SC_CLV:  v_d = 1'b0;
        default: ;
      endcase
    end else begin
      if (flag_we[0]) c_d = alu_flag[0];
      if (flag_we[1]) z_d = alu_flag[1];
      if (flag_we[2]) i_d = alu_flag[2];
      if (flag_we[6]) v_d = alu_flag[6];
      if (flag_we[7]) n_d = alu_flag[7];
`ifdef STATUS_REG_DECIMAL_EN
      if (flag_we[3]) d_d = alu_flag[3];
`endif
    end
    if (int_ack) i_d = 1'b1;
  end

  // P register; reset value is 8'h24 (only I set among the stored flags).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      i_q <= 1'b1;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      i_q <= i_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

`ifdef STATUS_REG_DECIMAL_EN
  // D flag storage, present only when decimal mode is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end
`else
  assign d_q = 1'b0;
`endif

  // A falling NMI_N against a high previous sample is a new NMI; a held-low line cannot retrigger.
  assign nmi_edge = nmi_smp_q & ~nmi_n;

  // NMI sample and pending latch; a fresh edge wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_smp_q  <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_smp_q <= nmi_n;
      if (nmi_edge) begin
        nmi_pend_q <= 1'b1;
      end else if (nmi_ack) begin
        nmi_pend_q <= 1'b0;
      end
    end
  end

  // IRQ take request, re-evaluated only at instruction boundaries against the pre-update I flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= 1'b0;
    end else if (int_ack) begin
      irq_pend_q <= 1'b0;
    end else if (instr_end) begin
      irq_pend_q <= ~irq_n & ~i_q;
    end
  end

  assign flag      = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign push_data = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign irq_pend  = irq_pend_q;
  assign nmi_pend  = nmi_pend_q;

endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 RST_N  in  1  asynchronous, active-low reset.
REQ-003 ALU_FLAG  in  8  flag vector from ALU; bit order N,V,_,B,D,I,Z,C (bit7..bit0).
REQ-004 FLAG_WE  in  8  per-bit write mask selecting which ALU_FLAG bits update P.
REQ-005 SET_CTRL  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV.
REQ-006 DB_IN  in  8  data-bus byte for PLP/RTI restore.
REQ-007 LOAD_DB  in  1  load P from DB_IN.
REQ-008 PUSH_BRK  in  1  selects B value in PUSH_DATA (1 = BRK/PHP, 0 = IRQ/NMI).
REQ-009 IRQ_N  in  1  level-sensitive interrupt request, active-low.
REQ-010 NMI_N  in  1  edge-sensitive non-maskable interrupt, active-low.
REQ-011 INSTR_END  in  1  one-cycle pulse at instruction boundary.
REQ-012 INT_ACK  in  1  interrupt entry taken; sets I.
REQ-013 NMI_ACK  in  1  clears pending NMI.
REQ-014 FLAG  out  8  current P register, fed to ALU FLAG_IN.
REQ-015 PUSH_DATA  out  8  P as written to stack.
REQ-016 IRQ_PEND  out  1  registered IRQ-take request.
REQ-017 NMI_PEND  out  1  registered NMI-take request.

Function
REQ-018 P stores C,Z,I,D,V,N; FLAG[5] SHALL always read 1, FLAG[4] SHALL always read 0.
REQ-019 Update priority per cycle: LOAD_DB > SET_CTRL != 0 > FLAG_WE; lower-priority sources SHALL be ignored that cycle.
REQ-020 LOAD_DB: P <= DB_IN, bits 5/4 discarded per REQ-018.
REQ-021 SET_CTRL: only the named bit changes; all other bits hold.
REQ-022 FLAG_WE: P[k] <= ALU_FLAG[k] for each k with FLAG_WE[k]=1; FLAG_WE[5:4] ignored.
REQ-023 INT_ACK SHALL force I=1 in the same update, overriding any I value from REQ-019 sources.
REQ-024 PUSH_DATA = {N,V,1,PUSH_BRK,D,I,Z,C}, combinational from registered P.
REQ-025 NMI edge detector: registered NMI_N sample; prev=1 and NMI_N=0 SHALL set NMI_PEND next edge.
REQ-026 NMI_ACK clears NMI_PEND; new edge coincident with NMI_ACK SHALL leave NMI_PEND=1.
REQ-027 NMI_N held low SHALL not re-trigger until it returns high for at least one cycle.
REQ-028 IRQ_PEND updates only when INSTR_END=1: IRQ_PEND <= ~IRQ_N & ~I, using I registered before that cycle's update (CLI/SEI/PLP take effect one instruction late); otherwise holds.
REQ-029 INT_ACK SHALL clear IRQ_PEND next edge.
REQ-030 FLAG changes one cycle after the controlling input; no combinational path from inputs to FLAG.

Reset
REQ-031 RST_N low SHALL asynchronously set FLAG=8'h24 (I=1), IRQ_PEND=0, NMI_PEND=0, NMI sample register=1.
REQ-032 Reset mid-operation SHALL discard any pending NMI edge and IRQ request; first update occurs on first rising edge after RST_N deasserts.

Configuration
REQ-033 Macro STATUS_REG_DECIMAL_EN defined: D bit writable via SET_CTRL, FLAG_WE, LOAD_DB.
REQ-034 Macro undefined: D SHALL read 0 permanently; SED, FLAG_WE[3], DB_IN[3] have no effect; PUSH_DATA[3]=0.

Verification
REQ-035 Reset: RST_N low mid-cycle -> FLAG=8'h24, IRQ_PEND=0, NMI_PEND=0 immediately.
REQ-036 FLAG_WE=8'h83, ALU_FLAG=8'h81, SET_CTRL=0 -> FLAG=8'hA5 next cycle; then SET_CTRL=1 -> FLAG=8'hA4.
REQ-037 LOAD_DB=1, DB_IN=8'hFF, SET_CTRL=1, INT_ACK=0 -> FLAG=8'hEF (decimal enabled) or 8'hE7 (disabled); PUSH_DATA with PUSH_BRK=1 = 8'hFF / 8'hF7.
REQ-038 IRQ_N=0, I=1, SET_CTRL=3 (CLI) with INSTR_END=1 -> IRQ_PEND=0; next INSTR_END -> IRQ_PEND=1; INT_ACK -> I=1, IRQ_PEND=0.
REQ-039 NMI_N 1->0 held low 10 cycles, NMI_ACK pulsed at cycle 3 -> NMI_PEND=1 at cycle 1, 0 after ack, no re-set; NMI_N 1->0 again coincident with NMI_ACK -> NMI_PEND stays 1.
REQ-040 Decimal disabled build: SET_CTRL=6 (SED) -> FLAG[3]=0, all other bits unchanged.
